// File: rtl/alu_operand_loader.sv
// alu_operand_loader
//   Collects operand A, operand B and the opcode from a shared switch bus
//   on three successive presses of a load button. It then presents them as one
//   valid-qualified bundle and holds it until the downstream stage takes it.
//   Optional macro LOADER_DEBOUNCE_EN: synchronise and debounce the button
//   before edge detection. Without it, the raw button level is used directly.
module alu_operand_loader #(
   parameter int M               = 4,
   parameter int OPW             = 4,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [M-1:0]   dato,
   input  logic           cargar,
   input  logic           borrar,
   input  logic           listo,
   output logic [M-1:0]   expresionA,
   output logic [M-1:0]   expresionB,
   output logic [OPW-1:0] opcode,
   output logic           valido,
   output logic [1:0]     estado
);

   // Parameter sanity checks at elaboration time.
   generate
      if (OPW > M) begin : g_bad_opw
         $fatal(1, "alu_operand_loader: OPW must not exceed M");
      end
      if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
         $fatal(1, "alu_operand_loader: DEBOUNCE_CYCLES must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_A     = 2'd0,
      S_B     = 2'd1,
      S_OP    = 2'd2,
      S_VALID = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             w_cargar_f;
   logic             r_cargar_q;
   logic             w_pulso;
   logic             w_ld_a;
   logic             w_ld_b;
   logic             w_ld_op;
   logic [M-1:0]     r_exp_a;
   logic [M-1:0]     r_exp_b;
   logic [OPW-1:0]   r_opcode;

`ifdef LOADER_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_deb;
   logic [CW-1:0] r_cnt;

   // Two-flop synchroniser followed by a filter. The filtered level follows the
   // synchronised input only after it has disagreed for DEBOUNCE_CYCLES cycles
   // in a row. Reset high so that a held button looks like "already pressed".
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_deb   <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= cargar;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_deb) begin
            if (r_cnt == CNT_LAST) begin
               r_deb <= r_sync2;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign w_cargar_f = r_deb;
`else
   assign w_cargar_f = cargar;
`endif

   // Previous filtered button level, used for rising-edge detection.
   // It is set to 1 on reset, so a button held through reset produces no edge.
   always_ff @(posedge clk) begin
      if (rst) r_cargar_q <= 1'b1;
      else     r_cargar_q <= w_cargar_f;
   end

   assign w_pulso = w_cargar_f & ~r_cargar_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_A;
      else     r_state <= w_next;
   end

   // Next-state logic. borrar wins over both pulso and listo.
   always_comb begin
      w_next = r_state;
      if (borrar) begin
         w_next = S_A;
      end else begin
         unique case (r_state)
            S_A:     if (w_pulso) w_next = S_B;
            S_B:     if (w_pulso) w_next = S_OP;
            S_OP:    if (w_pulso) w_next = S_VALID;
            S_VALID: if (listo)   w_next = S_A;
            default: w_next = S_A;
         endcase
      end
   end

   // Output decode: capture strobes and the bundle-valid flag.
   always_comb begin
      w_ld_a  = 1'b0;
      w_ld_b  = 1'b0;
      w_ld_op = 1'b0;
      valido  = 1'b0;
      unique case (r_state)
         S_A:     w_ld_a  = w_pulso & ~borrar;
         S_B:     w_ld_b  = w_pulso & ~borrar;
         S_OP:    w_ld_op = w_pulso & ~borrar;
         S_VALID: valido  = 1'b1;
         default: ;
      endcase
   end

   // Operand and opcode registers. They change only on a capture or on reset,
   // so their values are kept across the handshake and across borrar.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exp_a  <= '0;
         r_exp_b  <= '0;
         r_opcode <= '0;
      end else begin
         if (w_ld_a)  r_exp_a  <= dato;
         if (w_ld_b)  r_exp_b  <= dato;
         if (w_ld_op) r_opcode <= dato[OPW-1:0];
      end
   end

   assign expresionA = r_exp_a;
   assign expresionB = r_exp_b;
   assign opcode     = r_opcode;
   assign estado     = r_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed, table-driven bench for alu_operand_loader (M=4, OPW=4).
// With LOADER_DEBOUNCE_EN defined, it runs the debounce sequences instead.
module tb_alu_operand_loader;

   localparam int M   = 4;
   localparam int OPW = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [M-1:0]   dato;
   logic           cargar;
   logic           borrar;
   logic           listo;
   logic [M-1:0]   expresionA;
   logic [M-1:0]   expresionB;
   logic [OPW-1:0] opcode;
   logic           valido;
   logic [1:0]     estado;

   int n_cmp = 0;
   int n_err = 0;

   alu_operand_loader #(.M(M), .OPW(OPW), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .dato(dato), .cargar(cargar), .borrar(borrar),
      .listo(listo), .expresionA(expresionA), .expresionB(expresionB),
      .opcode(opcode), .valido(valido), .estado(estado)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic           rst;
      logic           cargar;
      logic           borrar;
      logic           listo;
      logic [M-1:0]   dato;
      logic [1:0]     e_st;
      logic [M-1:0]   e_a;
      logic [M-1:0]   e_b;
      logic [OPW-1:0] e_op;
      logic           e_v;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic c, input logic b,
                               input logic l, input logic [3:0] d,
                               input logic [1:0] st, input logic [3:0] a,
                               input logic [3:0] bb, input logic [3:0] op,
                               input logic v);
      vec_t x;
      x.rst = r; x.cargar = c; x.borrar = b; x.listo = l; x.dato = d;
      x.e_st = st; x.e_a = a; x.e_b = bb; x.e_op = op; x.e_v = v;
      return x;
   endfunction

   task automatic chk(input string name, input int idx, input logic [7:0] act,
                      input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic check_all(input int idx, input vec_t v);
      chk("estado", idx, {6'd0, estado}, {6'd0, v.e_st});
      chk("expresionA", idx, {4'd0, expresionA}, {4'd0, v.e_a});
      chk("expresionB", idx, {4'd0, expresionB}, {4'd0, v.e_b});
      chk("opcode", idx, {4'd0, opcode}, {4'd0, v.e_op});
      chk("valido", idx, {7'd0, valido}, {7'd0, v.e_v});
   endtask

   // Drive the given inputs, let one rising edge pass, then sample 1 time unit after it.
   task automatic step(input logic r, input logic c, input logic b,
                       input logic l, input logic [3:0] d);
      rst = r; cargar = c; borrar = b; listo = l; dato = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; cargar = 1'b0; borrar = 1'b0; listo = 1'b0; dato = '0;

`ifndef LOADER_DEBOUNCE_EN
      //           rst cg br ls dato  st  A     B     OP    v
      tbl.push_back(mk(1, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0)); // reset
      tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 4'hA, 1, 4'hA, 4'h0, 4'h0, 0)); // A
      tbl.push_back(mk(0, 0, 0, 0, 4'h0, 1, 4'hA, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 4'h5, 2, 4'hA, 4'h5, 4'h0, 0)); // B
      tbl.push_back(mk(0, 0, 0, 0, 4'h0, 2, 4'hA, 4'h5, 4'h0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 4'h3, 3, 4'hA, 4'h5, 4'h3, 1)); // OP -> valid
      tbl.push_back(mk(0, 0, 0, 0, 4'h7, 3, 4'hA, 4'h5, 4'h3, 1)); // listo low x5
      tbl.push_back(mk(0, 1, 0, 0, 4'h7, 3, 4'hA, 4'h5, 4'h3, 1)); // pulse ignored
      tbl.push_back(mk(0, 0, 0, 0, 4'h7, 3, 4'hA, 4'h5, 4'h3, 1));
      tbl.push_back(mk(0, 1, 0, 0, 4'h7, 3, 4'hA, 4'h5, 4'h3, 1)); // pulse ignored
      tbl.push_back(mk(0, 0, 0, 0, 4'h7, 3, 4'hA, 4'h5, 4'h3, 1));
      tbl.push_back(mk(0, 0, 0, 1, 4'h0, 0, 4'hA, 4'h5, 4'h3, 0)); // handshake
      tbl.push_back(mk(0, 1, 0, 0, 4'hF, 1, 4'hF, 4'h5, 4'h3, 0)); // held 4 cycles
      tbl.push_back(mk(0, 1, 0, 0, 4'h9, 1, 4'hF, 4'h5, 4'h3, 0));
      tbl.push_back(mk(0, 1, 0, 0, 4'h9, 1, 4'hF, 4'h5, 4'h3, 0));
      tbl.push_back(mk(0, 1, 0, 0, 4'h9, 1, 4'hF, 4'h5, 4'h3, 0));
      tbl.push_back(mk(0, 0, 0, 0, 4'h0, 1, 4'hF, 4'h5, 4'h3, 0));
      tbl.push_back(mk(0, 1, 1, 0, 4'h6, 0, 4'hF, 4'h5, 4'h3, 0)); // borrar + edge
      tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 4'hF, 4'h5, 4'h3, 0));
      tbl.push_back(mk(0, 1, 0, 0, 4'h2, 1, 4'h2, 4'h5, 4'h3, 0));
      tbl.push_back(mk(0, 0, 0, 0, 4'h0, 1, 4'h2, 4'h5, 4'h3, 0));
      tbl.push_back(mk(0, 1, 0, 0, 4'hC, 2, 4'h2, 4'hC, 4'h3, 0));
      tbl.push_back(mk(0, 0, 0, 0, 4'h0, 2, 4'h2, 4'hC, 4'h3, 0));
      tbl.push_back(mk(1, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0)); // rst mid-sequence
      tbl.push_back(mk(1, 1, 0, 0, 4'h9, 0, 4'h0, 4'h0, 4'h0, 0)); // held through rst
      tbl.push_back(mk(0, 1, 0, 0, 4'h9, 0, 4'h0, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 4'h9, 0, 4'h0, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 4'h8, 1, 4'h8, 4'h0, 4'h0, 0)); // re-press
      tbl.push_back(mk(0, 0, 0, 0, 4'h0, 1, 4'h8, 4'h0, 4'h0, 0));
      tbl.push_back(mk(0, 1, 0, 1, 4'h4, 2, 4'h8, 4'h4, 4'h0, 0)); // listo ignored in S_B
      tbl.push_back(mk(0, 0, 0, 1, 4'h0, 2, 4'h8, 4'h4, 4'h0, 0));
      tbl.push_back(mk(0, 1, 0, 1, 4'hE, 3, 4'h8, 4'h4, 4'hE, 1));
      tbl.push_back(mk(0, 0, 0, 1, 4'h0, 0, 4'h8, 4'h4, 4'hE, 0)); // listo on entry

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].cargar, tbl[i].borrar, tbl[i].listo, tbl[i].dato);
         check_all(i, tbl[i]);
      end

      // Hand sequence: borrar in S_VALID drops the bundle and keeps the registers.
      step(0, 1, 0, 0, 4'h1); step(0, 0, 0, 0, 4'h0);
      step(0, 1, 0, 0, 4'h2); step(0, 0, 0, 0, 4'h0);
      step(0, 1, 0, 0, 4'h6);
      check_all(100, mk(0, 0, 0, 0, 0, 3, 4'h1, 4'h2, 4'h6, 1));
      step(0, 0, 1, 0, 4'h0);
      check_all(101, mk(0, 0, 0, 0, 0, 0, 4'h1, 4'h2, 4'h6, 0));
`else
      // Debounce: settle the filtered level low after reset.
      step(1, 0, 0, 0, 4'h0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 4'h0);
      check_all(0, mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));
      // 3-cycle glitch: no capture.
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 4'h5);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 4'h5);
      check_all(1, mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));
      // 6-cycle press: capture lands 2+4+1 edges after the first high sample.
      for (int i = 0; i < 7; i++) begin
         step(0, (i < 6), 0, 0, 4'hA);
         if (i < 6) check_all(10 + i, mk(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0));
         else       check_all(10 + i, mk(0, 0, 0, 0, 0, 1, 4'hA, 4'h0, 4'h0, 0));
      end
      for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 4'h3);
      check_all(20, mk(0, 0, 0, 0, 0, 1, 4'hA, 4'h0, 4'h0, 0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
